booth_multiplier_seq: RTL and testbench

//  Iterative radix-2 Booth multiplier for signed two's-complement operands.

---
 rtl/booth_multiplier_seq_pkg.sv | 29 ++
 rtl/booth_multiplier_seq_step.sv | 35 +++
 rtl/booth_multiplier_seq.sv | 101 ++++++++++
 tb/tb_booth_multiplier_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/booth_multiplier_seq_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier:
// FSM state encodings and Booth recoding op codes.
package booth_multiplier_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } op_t;

  function automatic op_t booth_op(
    input logic q0,
    input logic q_m1
  );
    op_t op;
    unique case ({q0, q_m1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_multiplier_seq_step.sv
// One radix-2 Booth step: add/sub multiplicand, then
// arithmetic right shift of {acc,q,q_m1}.
module booth_multiplier_seq_step
  import booth_multiplier_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH:0]   acc,
  input  logic        [WIDTH-1:0] q,
  input  logic                    q_m1,
  input  logic signed [WIDTH:0]   m,
  output logic signed [WIDTH:0]   acc_next,
  output logic        [WIDTH-1:0] q_next,
  output logic                    q_m1_next
);

  op_t                  op;
  logic signed [WIDTH:0] sum;

  assign op = booth_op(q[0], q_m1);

  always_comb begin
    sum = acc;
    unique case (op)
      BOOTH_ADD: sum = acc + m;
      BOOTH_SUB: sum = acc - m;
      default:   sum = acc;
    endcase
  end

  assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_next = q[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// Iterative signed Booth multiplier: one step per clock,
// start/busy/done handshake, product held until next done.
module booth_multiplier_seq
  import booth_multiplier_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      busy,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] z
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                state;
  state_t                state_next;
  logic signed [WIDTH:0] acc;
  logic signed [WIDTH:0] m;
  logic signed [WIDTH:0] acc_step;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      q_step;
  logic                  q_m1;
  logic                  q_m1_step;
  logic [CW-1:0]         cnt;
  logic                  load;
  logic                  finish;

  booth_multiplier_seq_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc      (acc),
    .q        (q),
    .q_m1     (q_m1),
    .m        (m),
    .acc_next (acc_step),
    .q_next   (q_step),
    .q_m1_next(q_m1_step)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt == CW'(1)) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      q    <= '0;
      q_m1 <= 1'b0;
      m    <= '0;
      cnt  <= '0;
      done <= 1'b0;
      z    <= '0;
    end else begin
      done <= finish;
      if (load) begin
        acc  <= '0;
        q    <= b;
        q_m1 <= 1'b0;
        m    <= {a[WIDTH-1], a};
        cnt  <= CW'(WIDTH);
      end else if (state == ST_CALC) begin
        acc  <= acc_step;
        q    <= q_step;
        q_m1 <= q_m1_step;
        cnt  <= cnt - 1'b1;
      end
      // Product is taken from the shifted value of the final step.
      if (finish) z <= {acc_step[WIDTH-1:0], q_step};
    end
  end

  assign busy = (state == ST_CALC);

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Scoreboard bench: WIDTH=4 and WIDTH=8 instances, directed
// vectors with hand-computed products, latency and pulse checks.
module tb_booth_multiplier_seq;

  typedef struct {
    longint z;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              start4 = 1'b0;
  logic signed [3:0] a4 = '0;
  logic signed [3:0] b4 = '0;
  logic              busy4;
  logic              done4;
  logic signed [7:0] z4;
  longint            e4 = 0;

  logic               start8 = 1'b0;
  logic signed [7:0]  a8 = '0;
  logic signed [7:0]  b8 = '0;
  logic               busy8;
  logic               done8;
  logic signed [15:0] z8;
  longint             e8 = 0;

  exp_t q4[$];
  exp_t q8[$];
  int   rem4 = 0;
  int   rem8 = 0;
  int   cyc = 0;
  logic done4_prev = 1'b0;
  logic done8_prev = 1'b0;
  int   passed = 0;
  int   total = 0;

  booth_multiplier_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .z(z4)
  );

  booth_multiplier_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .z(z8)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, got, exp);
  endtask

  // Acceptance model: idle when rem==0, busy for WIDTH edges after accept.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      rem4 = 0;
      rem8 = 0;
      q4.delete();
      q8.delete();
    end else begin
      if (rem4 == 0 && start4) begin
        q4.push_back('{z: e4, cyc: cyc + 4});
        rem4 = 4;
      end else if (rem4 > 0) rem4--;
      if (rem8 == 0 && start8) begin
        q8.push_back('{z: e8, cyc: cyc + 8});
        rem8 = 8;
      end else if (rem8 > 0) rem8--;
    end
  end

  always @(negedge clk) begin
    exp_t it;
    if (rst_n && done4) begin
      check("done4_width", longint'(done4_prev), 0);
      if (q4.size() == 0) check("done4_unexpected", 1, 0);
      else begin
        it = q4.pop_front();
        check("z4", longint'(z4), it.z);
        check("lat4", longint'(cyc), longint'(it.cyc));
      end
    end
    if (rst_n && done8) begin
      check("done8_width", longint'(done8_prev), 0);
      if (q8.size() == 0) check("done8_unexpected", 1, 0);
      else begin
        it = q8.pop_front();
        check("z8", longint'(z8), it.z);
        check("lat8", longint'(cyc), longint'(it.cyc));
      end
    end
    done4_prev = done4;
    done8_prev = done8;
  end

  task automatic run4(input int av, input int bv, input longint ev);
    @(negedge clk);
    a4 = 4'(av); b4 = 4'(bv); e4 = ev; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run8(input int av, input int bv, input longint ev);
    @(negedge clk);
    a8 = 8'(av); b8 = 8'(bv); e8 = ev; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1;
    check("rst_busy4", longint'(busy4), 0);
    check("rst_done4", longint'(done4), 0);
    check("rst_z4", longint'(z4), 0);
    check("rst_z8", longint'(z8), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run4(-7, 3, -21);
    run4(-7, 7, -49);
    run4(-7, -7, 49);
    run4(-8, -8, 64);
    run4(-8, 6, -48);
    run4(5, -8, -40);
    run4(0, -8, 0);
    run4(7, 7, 49);

    run8(-128, -128, 16384);
    run8(127, -128, -16256);
    run8(-1, -1, 1);
    run8(100, -3, -300);

    // Held start: three accepts spaced WIDTH+1 cycles.
    @(negedge clk);
    a4 = 4'sd2; b4 = 4'sd3; e4 = 6; start4 = 1'b1;
    repeat (15) @(negedge clk);
    start4 = 1'b0;
    repeat (6) @(negedge clk);

    // Start pulse while busy must be ignored.
    a4 = 4'sd2; b4 = 4'sd3; e4 = 6; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    a4 = 4'sd1; b4 = 4'sd1; e4 = 1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (6) @(negedge clk);

    // Reset mid-operation.
    a4 = -4'sd5; b4 = -4'sd5; e4 = 25; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy4", longint'(busy4), 0);
    check("mid_rst_done4", longint'(done4), 0);
    check("mid_rst_z4", longint'(z4), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run4(-5, -5, 25);

    // Operands wander while busy; product uses captured values.
    @(negedge clk);
    a4 = 4'sd3; b4 = 4'sd4; e4 = 12; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);

    check("q4_drained", longint'(q4.size()), 0);
    check("q8_drained", longint'(q8.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
